// File: rtl/com_dm_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | com_dm_sequencer                                                           |
// | Streams a job into DM, hands DM to the processor, streams results back out.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module com_dm_sequencer #(
  parameter logic [15:0] LOAD_BASE   = 16'h0000,
  parameter int unsigned LOAD_LEN    = 256,
  parameter logic [15:0] RESULT_BASE = 16'h0100,
  parameter int unsigned RESULT_LEN  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic [15:0] i_in_data,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  output logic [15:0] o_out_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output logic        o_proc_start,
  input  logic        i_proc_done,
  output logic [1:0]  o_status,
  output logic [15:0] o_com_data_in,
  output logic [15:0] o_com_addr,
  output logic        o_com_wr_en,
  input  logic [15:0] i_com_data_out,
  output logic        o_busy,
  output logic        o_done
);

  localparam logic [15:0] C_LOAD_LAST   = 16'(LOAD_LEN - 1);
  localparam logic [15:0] C_RESULT_LAST = 16'(RESULT_LEN - 1);
  localparam logic [1:0]  C_ST_COM_WR   = 2'b00;
  localparam logic [1:0]  C_ST_PROC     = 2'b01;
  localparam logic [1:0]  C_ST_COM_RD   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WRITE   = 3'd2,
    S_RUN     = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_CAP  = 3'd5,
    S_OUT     = 3'd6,
    S_FIN     = 3'd7
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_cnt, w_cnt_next;
  logic [1:0]  w_status;
  logic        w_accept;

  logic        r_in_ready, r_out_valid, r_proc_start, r_com_wr_en, r_busy, r_done;
  logic [15:0] r_out_data, r_com_data_in, r_com_addr;
  logic [1:0]  r_status;

  assign w_accept = (r_state == S_LOAD) && i_in_valid && r_in_ready;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next     = S_LOAD;
          w_cnt_next = '0;
        end
      end
      S_LOAD:    if (w_accept) w_next = S_WRITE;
      S_WRITE: begin
        if (r_cnt == C_LOAD_LAST) begin
          w_next = S_RUN;
        end else begin
          w_next     = S_LOAD;
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_RUN: begin
        if (i_proc_done) begin
          w_next     = S_RD_ADDR;
          w_cnt_next = '0;
        end
      end
      S_RD_ADDR: w_next = S_RD_CAP;
      S_RD_CAP:  w_next = S_OUT;
      S_OUT: begin
        if (i_out_ready) begin
          if (r_cnt == C_RESULT_LAST) begin
            w_next = S_FIN;
          end else begin
            w_next     = S_RD_ADDR;
            w_cnt_next = r_cnt + 16'd1;
          end
        end
      end
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Selector mode follows the state being entered, so it is valid in that state's first cycle.
  always_comb begin
    w_status = C_ST_COM_WR;
    case (w_next)
      S_RUN:                       w_status = C_ST_PROC;
      S_RD_ADDR, S_RD_CAP, S_OUT:  w_status = C_ST_COM_RD;
      default:                     w_status = C_ST_COM_WR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_data    <= '0;
      r_proc_start  <= 1'b0;
      r_status      <= C_ST_COM_WR;
      r_com_data_in <= '0;
      r_com_addr    <= '0;
      r_com_wr_en   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_in_ready   <= (w_next == S_LOAD);
      r_com_wr_en  <= (w_next == S_WRITE);
      r_proc_start <= (w_next == S_RUN) && (r_state != S_RUN);
      r_busy       <= (w_next != S_IDLE);
      r_done       <= (w_next == S_FIN);
      r_status     <= w_status;

      if (w_accept) begin
        r_com_data_in <= i_in_data;
        r_com_addr    <= LOAD_BASE + r_cnt;
      end else if (w_next == S_RD_ADDR) begin
        r_com_addr    <= RESULT_BASE + w_cnt_next;
      end

      // DM read data arrives the cycle after the address, i.e. during RD_CAP.
      if (r_state == S_RD_CAP) begin
        r_out_data  <= i_com_data_out;
        r_out_valid <= 1'b1;
      end else if ((r_state == S_OUT) && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign o_in_ready    = r_in_ready;
  assign o_out_data    = r_out_data;
  assign o_out_valid   = r_out_valid;
  assign o_proc_start  = r_proc_start;
  assign o_status      = r_status;
  assign o_com_data_in = r_com_data_in;
  assign o_com_addr    = r_com_addr;
  assign o_com_wr_en   = r_com_wr_en;
  assign o_busy        = r_busy;
  assign o_done        = r_done;

endmodule
`default_nettype wire
